// File: rtl/mem_lsu_pkg.sv
// Shared widths, memory opcodes, result selector and LSU state encoding.
// Imported by the load/store unit and its lane-alignment helper.
package mem_lsu_pkg;

    localparam int REG_BUS       = 32;
    localparam int REG_ADDR_BUS  = 5;
    localparam int ALU_OP_BUS    = 8;
    localparam int INST_ADDR_BUS = 32;

    localparam logic [ALU_OP_BUS-1:0] EXE_OR_OP   = 8'h25;
    localparam logic [ALU_OP_BUS-1:0] EXE_LD_B_OP  = 8'h80;
    localparam logic [ALU_OP_BUS-1:0] EXE_LD_H_OP  = 8'h81;
    localparam logic [ALU_OP_BUS-1:0] EXE_LD_W_OP  = 8'h82;
    localparam logic [ALU_OP_BUS-1:0] EXE_LD_BU_OP = 8'h83;
    localparam logic [ALU_OP_BUS-1:0] EXE_LD_HU_OP = 8'h84;
    localparam logic [ALU_OP_BUS-1:0] EXE_ST_B_OP  = 8'h88;
    localparam logic [ALU_OP_BUS-1:0] EXE_ST_H_OP  = 8'h89;
    localparam logic [ALU_OP_BUS-1:0] EXE_ST_W_OP  = 8'h8a;

    localparam logic [2:0] EXE_RES_LOAD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } lsu_state_t;

    function automatic logic is_load(input logic [ALU_OP_BUS-1:0] op);
        return (op == EXE_LD_B_OP) || (op == EXE_LD_H_OP) || (op == EXE_LD_W_OP) ||
               (op == EXE_LD_BU_OP) || (op == EXE_LD_HU_OP);
    endfunction

    function automatic logic is_store(input logic [ALU_OP_BUS-1:0] op);
        return (op == EXE_ST_B_OP) || (op == EXE_ST_H_OP) || (op == EXE_ST_W_OP);
    endfunction

    function automatic logic is_misaligned(input logic [ALU_OP_BUS-1:0] op,
                                           input logic [1:0] lo);
        logic half;
        logic word;
        half = (op == EXE_LD_H_OP) || (op == EXE_LD_HU_OP) || (op == EXE_ST_H_OP);
        word = (op == EXE_LD_W_OP) || (op == EXE_ST_W_OP);
        return (half && lo[0]) || (word && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Store byte-lane generator and load extractor, keyed by opcode and the
// low two address bits.
module lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [ALU_OP_BUS-1:0] aluop,
    input  logic [1:0]            addr_lo,
    input  logic [REG_BUS-1:0]    reg2,
    input  logic [REG_BUS-1:0]    rdata,
    output logic [3:0]            we,
    output logic [REG_BUS-1:0]    wdata,
    output logic [REG_BUS-1:0]    load_data
);

    logic [REG_BUS-1:0] shifted;

    assign shifted = rdata >> {addr_lo, 3'b000};

    // Byte lane gi carries the byte, half-word half or word byte that lands on it.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wdata[8*gi +: 8] = (aluop == EXE_ST_B_OP) ? reg2[7:0] :
                                      (aluop == EXE_ST_H_OP) ? reg2[8*(gi%2) +: 8] :
                                                               reg2[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        we = 4'b0000;
        case (aluop)
            EXE_ST_B_OP: we = 4'b0001 << addr_lo;
            EXE_ST_H_OP: we = 4'b0011 << addr_lo;
            EXE_ST_W_OP: we = 4'b1111;
            default:     we = 4'b0000;
        endcase
    end

    always_comb begin
        load_data = shifted;
        case (aluop)
            EXE_LD_B_OP:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            EXE_LD_BU_OP: load_data = {24'h0, shifted[7:0]};
            EXE_LD_H_OP:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            EXE_LD_HU_OP: load_data = {16'h0, shifted[15:0]};
            default:      load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: SRAM request/response handshake, alignment
// checks, load extension and pipeline stall generation.
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ALU_OP_BUS-1:0]    aluop_i,
    input  logic [31:0]              mem_addr_i,
    input  logic [REG_BUS-1:0]       reg2_i,
    input  logic [REG_ADDR_BUS-1:0]  wd_i,
    input  logic                     wreg_i,
    input  logic [REG_BUS-1:0]       wdata_i,
    input  logic                     inst_valid_i,
    input  logic [INST_ADDR_BUS-1:0] inst_pc_i,
    output logic [REG_ADDR_BUS-1:0]  wd_o,
    output logic                     wreg_o,
    output logic [REG_BUS-1:0]       wdata_o,
    output logic                     inst_valid_o,
    output logic [INST_ADDR_BUS-1:0] inst_pc_o,
    output logic                     excp_ale_o,
    output logic                     stallreq_o,
    output logic                     data_req_o,
    output logic [3:0]               data_we_o,
    output logic [31:0]              data_addr_o,
    output logic [31:0]              data_wdata_o,
    input  logic                     data_addr_ok_i,
    input  logic                     data_data_ok_i,
    input  logic [31:0]              data_rdata_i
);

    lsu_state_t state_reg, state_next;
    logic       pending_reg, pending_next;

    logic         mem_op, ale, go, resp;
    logic [3:0]   lane_we;
    logic [31:0]  lane_wdata, load_data;

    assign mem_op = inst_valid_i && (is_load(aluop_i) || is_store(aluop_i));
    assign ale    = mem_op && is_misaligned(aluop_i, mem_addr_i[1:0]);
    assign go     = mem_op && !ale;
    // data_ok only counts once the current access has been accepted.
    assign resp   = (state_reg == ST_WAIT) && pending_reg && data_data_ok_i;

    lsu_align u_align (
        .aluop     (aluop_i),
        .addr_lo   (mem_addr_i[1:0]),
        .reg2      (reg2_i),
        .rdata     (data_rdata_i),
        .we        (lane_we),
        .wdata     (lane_wdata),
        .load_data (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            pending_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        case (state_reg)
            ST_IDLE: begin
                if (go) begin
                    state_next   = data_addr_ok_i ? ST_WAIT : ST_REQ;
                    pending_next = data_addr_ok_i;
                end
            end
            ST_REQ: begin
                if (data_addr_ok_i) begin
                    state_next   = ST_WAIT;
                    pending_next = 1'b1;
                end
            end
            ST_WAIT: begin
                if (resp) begin
                    state_next   = ST_IDLE;
                    pending_next = 1'b0;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                pending_next = 1'b0;
            end
        endcase
    end

    always_comb begin
        wd_o         = '0;
        wreg_o       = 1'b0;
        wdata_o      = '0;
        inst_valid_o = 1'b0;
        inst_pc_o    = '0;
        excp_ale_o   = 1'b0;
        stallreq_o   = 1'b0;
        data_req_o   = 1'b0;
        data_we_o    = 4'b0000;
        data_addr_o  = '0;
        data_wdata_o = '0;
        if (!rst) begin
            wd_o         = wd_i;
            wreg_o       = wreg_i;
            wdata_o      = wdata_i;
            inst_valid_o = inst_valid_i;
            inst_pc_o    = inst_pc_i;
            data_req_o   = ((state_reg == ST_IDLE) && go) || (state_reg == ST_REQ);
            stallreq_o   = data_req_o || ((state_reg == ST_WAIT) && !resp);
            if (data_req_o) begin
                data_we_o    = lane_we;
                data_addr_o  = {mem_addr_i[31:2], 2'b00};
                data_wdata_o = lane_wdata;
            end
            if (ale) begin
                excp_ale_o = 1'b1;
                wreg_o     = 1'b0;
            end else if (mem_op && is_store(aluop_i)) begin
                wreg_o = 1'b0;
            end else if (mem_op) begin
                wdata_o = load_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed checks of mem_lsu: loads, stores, delayed handshakes,
// misalignment, reset mid-access and pass-through.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i, reg2_i, wdata_i, inst_pc_i, data_rdata_i;
    logic [4:0]  wd_i;
    logic        wreg_i, inst_valid_i, data_addr_ok_i, data_data_ok_i;
    logic [4:0]  wd_o;
    logic        wreg_o, inst_valid_o, excp_ale_o, stallreq_o, data_req_o;
    logic [31:0] wdata_o, inst_pc_o, data_addr_o, data_wdata_o;
    logic [3:0]  data_we_o;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_lsu dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
        .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .inst_valid_i(inst_valid_i), .inst_pc_i(inst_pc_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .inst_valid_o(inst_valid_o), .inst_pc_o(inst_pc_o),
        .excp_ale_o(excp_ale_o), .stallreq_o(stallreq_o),
        .data_req_o(data_req_o), .data_we_o(data_we_o),
        .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_addr_ok_i(data_addr_ok_i), .data_data_ok_i(data_data_ok_i),
        .data_rdata_i(data_rdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] r2, input logic [31:0] pc);
        aluop_i = op; mem_addr_i = addr; reg2_i = r2; inst_pc_i = pc;
        inst_valid_i = 1'b1; wreg_i = !is_store(op); wd_i = 5'd4; wdata_i = 32'h0;
    endtask

    task automatic set_nop();
        aluop_i = 8'h0; mem_addr_i = 0; reg2_i = 0; inst_pc_i = 0;
        inst_valid_i = 1'b0; wreg_i = 1'b0; wd_i = 5'd0; wdata_i = 0;
        data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0; data_rdata_i = 0;
    endtask

    // One-shot load: request accepted immediately, data one cycle later.
    task automatic quick_load(input string tag, input logic [7:0] op,
                              input logic [31:0] addr, input logic [31:0] rdata,
                              input logic [31:0] exp);
        set_op(op, addr, 32'h0, 32'h1c00_0100);
        data_addr_ok_i = 1'b1;
        #1;
        $display("txn %s: req=%0b addr=0x%08h", tag, data_req_o, data_addr_o);
        chk({tag, "_req"}, {31'h0, data_req_o}, 32'h1);
        next_cycle();
        data_addr_ok_i = 1'b0; data_data_ok_i = 1'b1; data_rdata_i = rdata;
        #1;
        chk({tag, "_wdata"}, wdata_o, exp);
        next_cycle();
        set_nop();
        #1;
    endtask

    initial begin
        set_nop();
        rst = 1'b1;
        set_op(EXE_LD_W_OP, 32'h1000, 32'h5555_5555, 32'h1c00_0000);
        data_addr_ok_i = 1'b1;
        #12;
        $display("txn reset: req=%0b stall=%0b valid=%0b", data_req_o, stallreq_o, inst_valid_o);
        chk("rst_req", {31'h0, data_req_o}, 32'h0);
        chk("rst_stall", {31'h0, stallreq_o}, 32'h0);
        chk("rst_addr", data_addr_o, 32'h0);
        chk("rst_valid_pc", {31'h0, inst_valid_o} | inst_pc_o, 32'h0);
        set_nop();
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // LD.W 0x1000, minimum latency
        set_op(EXE_LD_W_OP, 32'h1000, 32'h0, 32'h1c00_0010);
        data_addr_ok_i = 1'b1;
        #1;
        $display("txn ld.w: addr=0x%08h we=%b stall=%0b", data_addr_o, data_we_o, stallreq_o);
        chk("ldw_req", {31'h0, data_req_o}, 32'h1);
        chk("ldw_addr", data_addr_o, 32'h1000);
        chk("ldw_we", {28'h0, data_we_o}, 32'h0);
        chk("ldw_stall0", {31'h0, stallreq_o}, 32'h1);
        next_cycle();
        data_addr_ok_i = 1'b0; data_data_ok_i = 1'b1; data_rdata_i = 32'hDEAD_BEEF;
        #1;
        $display("txn ld.w resp: wdata=0x%08h wreg=%0b", wdata_o, wreg_o);
        chk("ldw_stall1", {31'h0, stallreq_o}, 32'h0);
        chk("ldw_req1", {31'h0, data_req_o}, 32'h0);
        chk("ldw_wdata", wdata_o, 32'hDEAD_BEEF);
        chk("ldw_wreg", {31'h0, wreg_o}, 32'h1);
        next_cycle();
        set_nop();

        quick_load("ldb", EXE_LD_B_OP, 32'h1003, 32'h8012_3456, 32'hFFFF_FF80);
        quick_load("ldbu", EXE_LD_BU_OP, 32'h1003, 32'h8012_3456, 32'h0000_0080);
        quick_load("ldh", EXE_LD_H_OP, 32'h1002, 32'h8012_3456, 32'hFFFF_8012);
        quick_load("ldhu", EXE_LD_HU_OP, 32'h1000, 32'h8012_F456, 32'h0000_F456);

        // ST.H 0x2002
        set_op(EXE_ST_H_OP, 32'h2002, 32'h1234_ABCD, 32'h1c00_0020);
        data_addr_ok_i = 1'b1;
        #1;
        $display("txn st.h: addr=0x%08h we=%b wdata=0x%08h", data_addr_o, data_we_o, data_wdata_o);
        chk("sth_addr", data_addr_o, 32'h2000);
        chk("sth_we", {28'h0, data_we_o}, 32'hC);
        chk("sth_wdata", data_wdata_o, 32'hABCD_ABCD);
        next_cycle();
        data_addr_ok_i = 1'b0; data_data_ok_i = 1'b1;
        #1;
        chk("sth_wreg", {31'h0, wreg_o}, 32'h0);
        chk("sth_stall", {31'h0, stallreq_o}, 32'h0);
        next_cycle();
        set_nop();

        // ST.B 0x3001
        set_op(EXE_ST_B_OP, 32'h3001, 32'h0000_00A5, 32'h1c00_0024);
        data_addr_ok_i = 1'b1;
        #1;
        $display("txn st.b: we=%b wdata=0x%08h", data_we_o, data_wdata_o);
        chk("stb_we", {28'h0, data_we_o}, 32'h2);
        chk("stb_wdata", data_wdata_o, 32'hA5A5_A5A5);
        next_cycle();
        data_addr_ok_i = 1'b0; data_data_ok_i = 1'b1;
        next_cycle();
        set_nop();

        // LD.W with addr_ok delayed 3 cycles, data_ok 2 cycles after acceptance
        set_op(EXE_LD_W_OP, 32'h4008, 32'h0, 32'h1c00_0030);
        for (int c = 0; c < 4; c++) begin
            data_addr_ok_i = (c == 3);
            data_data_ok_i = (c == 1);   // stray data_ok while in REQ
            data_rdata_i   = 32'h1111_1111;
            #1;
            $display("txn ld.w slow c%0d: req=%0b addr=0x%08h stall=%0b", c, data_req_o, data_addr_o, stallreq_o);
            chk("slow_req", {31'h0, data_req_o}, 32'h1);
            chk("slow_addr", data_addr_o, 32'h4008);
            chk("slow_stall", {31'h0, stallreq_o}, 32'h1);
            next_cycle();
        end
        data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0;
        #1;
        chk("slow_wait_req", {31'h0, data_req_o}, 32'h0);
        chk("slow_wait_stall", {31'h0, stallreq_o}, 32'h1);
        next_cycle();
        data_data_ok_i = 1'b1; data_rdata_i = 32'h0BAD_F00D;
        #1;
        $display("txn ld.w slow resp: wdata=0x%08h stall=%0b", wdata_o, stallreq_o);
        chk("slow_done_stall", {31'h0, stallreq_o}, 32'h0);
        chk("slow_wdata", wdata_o, 32'h0BAD_F00D);
        next_cycle();
        set_nop();

        // Misaligned LD.W
        set_op(EXE_LD_W_OP, 32'h1002, 32'h0, 32'h1c00_0040);
        data_addr_ok_i = 1'b1;
        #1;
        $display("txn ld.w misaligned: ale=%0b req=%0b stall=%0b wreg=%0b", excp_ale_o, data_req_o, stallreq_o, wreg_o);
        chk("ale_flag", {31'h0, excp_ale_o}, 32'h1);
        chk("ale_req", {31'h0, data_req_o}, 32'h0);
        chk("ale_stall", {31'h0, stallreq_o}, 32'h0);
        chk("ale_wreg", {31'h0, wreg_o}, 32'h0);
        next_cycle();
        set_nop();
        #1;

        // Reset in WAIT, then a stray data_ok
        set_op(EXE_LD_W_OP, 32'h5000, 32'h0, 32'h1c00_0050);
        data_addr_ok_i = 1'b1;
        next_cycle();
        data_addr_ok_i = 1'b0;
        rst = 1'b1;
        #1;
        $display("txn reset in wait: req=%0b stall=%0b wreg=%0b", data_req_o, stallreq_o, wreg_o);
        chk("rstw_stall", {31'h0, stallreq_o}, 32'h0);
        chk("rstw_wreg", {31'h0, wreg_o}, 32'h0);
        chk("rstw_pc", inst_pc_o, 32'h0);
        next_cycle();
        set_nop();
        rst = 1'b0;
        next_cycle();
        data_data_ok_i = 1'b1; data_rdata_i = 32'h7777_7777;
        #1;
        $display("txn stray data_ok: req=%0b stall=%0b wreg=%0b", data_req_o, stallreq_o, wreg_o);
        chk("stray_stall", {31'h0, stallreq_o}, 32'h0);
        chk("stray_wreg", {31'h0, wreg_o}, 32'h0);
        next_cycle();
        data_data_ok_i = 1'b0;

        // Pass-through OR
        aluop_i = EXE_OR_OP; inst_valid_i = 1'b1; wreg_i = 1'b1; wd_i = 5'd7;
        wdata_i = 32'hCAFE_F00D; inst_pc_i = 32'h1c00_0060; mem_addr_i = 32'h1001;
        #1;
        $display("txn or: wdata=0x%08h wd=%0d pc=0x%08h", wdata_o, wd_o, inst_pc_o);
        chk("or_wdata", wdata_o, 32'hCAFE_F00D);
        chk("or_wd", {27'h0, wd_o}, 32'd7);
        chk("or_pc", inst_pc_o, 32'h1c00_0060);
        chk("or_req_stall", {30'h0, data_req_o, stallreq_o}, 32'h0);
        chk("or_ale", {31'h0, excp_ale_o}, 32'h0);
        next_cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
